float16_accumulator: RTL and testbench
======================================

FLOAT16_ACCUMULATOR -- requirements
Module: float16_accumulator

Interface
REQ-001 SHALL have parameter COUNT_W, default 8: width of the element counter and of out_count.
REQ-002 SHALL have clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have in_data, input, 16: float16 product from the multiplication stage (sign bit 15, exponent bits 14:10 with bias 15, fraction bits 9:0).
REQ-005 SHALL have in_valid, input, 1, and in_ready, output, 1: input handshake; transfer occurs when both are high.
REQ-006 SHALL have in_last, input, 1: qualifies in_data as the final element of the current sum.
REQ-007 SHALL have out_data, output, 16: accumulated float16 sum.
REQ-008 SHALL have out_count, output, COUNT_W: number of elements accepted in the sum, wrapping modulo 2^COUNT_W.
REQ-009 SHALL have out_valid, output, 1, and out_ready, input, 1: output handshake.

Function
REQ-010 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, OUT.
REQ-011 SHALL drive in_ready high only in IDLE; all other states are busy.
REQ-012 SHALL, on an input transfer in IDLE, capture in_data and in_last and go to ALIGN.
REQ-013 SHALL, in ALIGN, shift the smaller-exponent mantissa right (hidden bit restored) by the exponent difference, keeping 3 guard bits; a difference above 13 SHALL zero it.
REQ-014 SHALL, in ADD, add or subtract the aligned 14-bit mantissas by sign, with the result sign taken from the larger magnitude.
REQ-015 SHALL, in NORM, normalize in one cycle using a leading-zero count, truncating guard bits (round toward zero), then go to OUT if the captured in_last is 1, otherwise to IDLE.
REQ-016 SHALL produce an accumulator-element latency of exactly 3 cycles per element: transfer cycle to the next in_ready high, or to out_valid high.
REQ-017 SHALL flush subnormal inputs (exponent 0) to zero, and SHALL represent a zero result as +0 (0x0000).
REQ-018 SHALL, on exponent overflow (biased exponent above 30), produce the overflow value defined in REQ-025 and REQ-026.
REQ-019 SHALL, on exponent underflow (biased exponent below 1), produce +0.
REQ-020 SHALL hold out_valid high in OUT with out_data and out_count stable until out_ready is high.
REQ-021 SHALL, on an output transfer, clear the accumulator to +0 and the counter to 0, and return to IDLE.
REQ-022 SHALL increment the counter on every input transfer, including the last element.

Reset
REQ-023 SHALL, while rst is high, force state IDLE, accumulator +0, counter 0, out_data 0x0000, out_count 0, out_valid 0, and in_ready 0; in_ready SHALL rise on the first cycle after rst falls.
REQ-024 SHALL abort any in-flight element or pending output when reset is asserted mid-operation, discarding it without emitting out_valid.

Configuration
REQ-025 SHALL, when FLOAT16_ACC_SAT_EN is defined, saturate overflow to signed maximum finite (0x7BFF or 0xFBFF).
REQ-026 SHALL, when FLOAT16_ACC_SAT_EN is undefined, produce signed infinity (0x7C00 or 0xFC00) on overflow; with either setting, inputs with exponent 31 are treated as infinity of their sign.

Structure
REQ-027 SHALL take float16 field widths, bias 15, constants POS_ZERO, POS_INF and MAX_FINITE, and the FSM state enum from shared package float16_pkg.
REQ-028 SHALL instantiate exactly one sub-module, float16_lzc, a combinational 14-bit leading-zero counter used in NORM.

Verification
REQ-029 SHALL cover: 0x3C00 (1.0), then 0x4000 (2.0) with in_last -> out_data 0x4200 (3.0), out_count 2.
REQ-030 SHALL cover: stream 0x4000, 0x4A00, 0x3C00, 0xC400 (last) -> out_data 0x4980 (11.0), out_count 4; in_ready low exactly 3 cycles after each transfer.
REQ-031 SHALL cover: 0xC000 then 0x4000 (last) -> out_data 0x0000, out_count 2.
REQ-032 SHALL cover: 0x7BFF then 0x7BFF (last) -> 0x7C00 without FLOAT16_ACC_SAT_EN, and 0x7BFF with it.
REQ-033 SHALL cover: out_ready held low for 5 cycles in OUT -> out_valid, out_data and out_count stable and in_ready low throughout; transfer on cycle 6, then accumulator restarts at +0.
REQ-034 SHALL cover: rst pulsed during ADD -> next cycle IDLE, out_valid 0; a following single element 0x3C00 (last) -> 0x3C00, out_count 1.

Source files
------------

// File: rtl/float16_pkg.sv
// Shared float16 field layout, special constants and accumulator FSM states.
// Build option: define FLOAT16_ACC_SAT_EN to saturate overflow to max finite instead of infinity.
package float16_pkg;

  localparam int EXP_W          = 5;
  localparam int FRAC_W         = 10;
  localparam int GUARD_W        = 3;
  localparam int MANT_W         = 1 + FRAC_W + GUARD_W;
  localparam int BIAS           = 15;
  localparam int EXP_MAX_NORMAL = 30;
  localparam int ALIGN_LIMIT    = 13;

  localparam logic [15:0] POS_ZERO   = 16'h0000;
  localparam logic [15:0] POS_INF    = 16'h7C00;
  localparam logic [15:0] MAX_FINITE = 16'h7BFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    OUT
  } acc_state_t;

  // Result produced when the normalized exponent leaves the finite range.
  function automatic logic [15:0] overflow_value(input logic sign);
`ifdef FLOAT16_ACC_SAT_EN
    return {sign, MAX_FINITE[14:0]};
`else
    return {sign, POS_INF[14:0]};
`endif
  endfunction

endpackage

// File: rtl/float16_lzc.sv
// Combinational leading-zero counter over the 14-bit aligned mantissa; all-zero input yields 14.
module float16_lzc
  import float16_pkg::*;
(
  input  logic [MANT_W-1:0] value,
  output logic [3:0]        count
);

  // Ascending scan so the highest set bit is the last one to write the count.
  always_comb begin
    count = 4'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (value[i]) count = 4'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/float16_accumulator.sv
// Multi-cycle float16 accumulator: IDLE -> ALIGN -> ADD -> NORM, then OUT on the last element.
// Build option FLOAT16_ACC_SAT_EN selects saturating overflow (see float16_pkg).
module float16_accumulator
  import float16_pkg::*;
#(
  parameter int COUNT_W = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  output logic [15:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  acc_state_t state, state_n;

  logic [15:0]        acc, op;
  logic               last_q;
  logic [COUNT_W-1:0] count;

  logic [MANT_W-1:0]  man_a_q, man_b_q;
  logic               sign_a_q, sign_b_q;
  logic [EXP_W-1:0]   exp_q;
  logic               special_q;
  logic [15:0]        special_val_q;

  logic [MANT_W:0]    sum_q;
  logic               sign_r_q;

  logic               xfer;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT) && !rst;
  assign out_data  = rst ? POS_ZERO : acc;
  assign out_count = rst ? '0 : count;
  assign xfer      = in_valid && in_ready;

  // Alignment: subnormals flush to zero, the smaller operand shifts right with guard bits kept.
  logic [EXP_W-1:0]  exp_a, exp_b, exp_diff, exp_big;
  logic [MANT_W-1:0] man_a, man_b, align_a, align_b;
  logic              inf_a, inf_b;

  always_comb begin
    exp_a = acc[14:10];
    exp_b = op[14:10];
    inf_a = &exp_a;
    inf_b = &exp_b;
    man_a = (exp_a == '0) ? '0 : {1'b1, acc[9:0], 3'b000};
    man_b = (exp_b == '0) ? '0 : {1'b1, op[9:0], 3'b000};
    if (exp_a >= exp_b) begin
      exp_big  = exp_a;
      exp_diff = exp_a - exp_b;
      align_a  = man_a;
      align_b  = (exp_diff > 5'(ALIGN_LIMIT)) ? '0 : (man_b >> exp_diff);
    end else begin
      exp_big  = exp_b;
      exp_diff = exp_b - exp_a;
      align_b  = man_b;
      align_a  = (exp_diff > 5'(ALIGN_LIMIT)) ? '0 : (man_a >> exp_diff);
    end
  end

  // Signed-magnitude add; on unlike signs the larger aligned mantissa decides the sign.
  logic [MANT_W:0] sum_n;
  logic            sign_n;

  always_comb begin
    if (sign_a_q == sign_b_q) begin
      sum_n  = {1'b0, man_a_q} + {1'b0, man_b_q};
      sign_n = sign_a_q;
    end else if (man_a_q >= man_b_q) begin
      sum_n  = {1'b0, man_a_q - man_b_q};
      sign_n = sign_a_q;
    end else begin
      sum_n  = {1'b0, man_b_q - man_a_q};
      sign_n = sign_b_q;
    end
  end

  logic [3:0]        lz;
  logic [MANT_W-1:0] shifted;
  logic signed [6:0] exp_norm;
  logic [5:0]        exp_inc;
  logic [15:0]       norm_res;

  float16_lzc u_lzc (
    .value (sum_q[MANT_W-1:0]),
    .count (lz)
  );

  // Normalization truncates the guard bits; a carry-out shifts right by one instead.
  always_comb begin
    exp_inc  = {1'b0, exp_q} + 6'd1;
    exp_norm = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
    shifted  = sum_q[MANT_W-1:0] << lz;
    norm_res = POS_ZERO;
    if (special_q) begin
      norm_res = special_val_q;
    end else if (sum_q == '0) begin
      norm_res = POS_ZERO;
    end else if (sum_q[MANT_W]) begin
      if (exp_inc > 6'(EXP_MAX_NORMAL)) norm_res = overflow_value(sign_r_q);
      else                              norm_res = {sign_r_q, exp_inc[4:0], sum_q[13:4]};
    end else if (exp_norm < 7'sd1) begin
      norm_res = POS_ZERO;
    end else begin
      norm_res = {sign_r_q, exp_norm[4:0], 10'(shifted >> GUARD_W)};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (xfer) state_n = ALIGN;
      ALIGN:   state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    state_n = last_q ? OUT : IDLE;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One pipeline stage of the datapath is registered per FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= POS_ZERO;
      count         <= '0;
      op            <= '0;
      last_q        <= 1'b0;
      man_a_q       <= '0;
      man_b_q       <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sum_q         <= '0;
      sign_r_q      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (xfer) begin
            op     <= in_data;
            last_q <= in_last;
            count  <= count + COUNT_W'(1);
          end
        end
        ALIGN: begin
          man_a_q       <= align_a;
          man_b_q       <= align_b;
          sign_a_q      <= acc[15];
          sign_b_q      <= op[15];
          exp_q         <= exp_big;
          special_q     <= inf_a || inf_b;
          special_val_q <= inf_a ? {acc[15], POS_INF[14:0]} : {op[15], POS_INF[14:0]};
        end
        ADD: begin
          sum_q    <= sum_n;
          sign_r_q <= sign_n;
        end
        NORM: acc <= norm_res;
        OUT: begin
          if (out_ready) begin
            acc   <= POS_ZERO;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float16_accumulator.sv
// Self-checking bench for float16_accumulator: directed cases plus random sums against a value-level model.
// Honours FLOAT16_ACC_SAT_EN for the expected overflow value.
module tb_float16_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_acc;
  int          model_cnt;

  float16_accumulator #(.COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ovf_value(input logic s);
`ifdef FLOAT16_ACC_SAT_EN
    return {s, 15'h7BFF};
`else
    return {s, 15'h7C00};
`endif
  endfunction

  // Value-level model: integer significands with 3 guard bits, truncating alignment and normalization.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, big, v, m, e;
    logic neg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31) return {a[15], 15'h7C00};
    if (eb == 31) return {b[15], 15'h7C00};
    ma = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 8;
    mb = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 8;
    big = (ea > eb) ? ea : eb;
    ma = (big - ea > 13) ? 0 : (ma >> (big - ea));
    mb = (big - eb > 13) ? 0 : (mb >> (big - eb));
    v = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    if (v == 0) return 16'h0000;
    neg = (v < 0);
    m = neg ? -v : v;
    e = big;
    while (m >= 16384) begin m = m >> 1; e++; end
    while (m < 8192)   begin m = m << 1; e--; end
    if (e > 30) return ovf_value(neg);
    if (e < 1)  return 16'h0000;
    return {neg, 5'(e), 10'((m >> 3) & 1023)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_acc = 16'h0000;
    model_cnt = 0;
  endtask

  // Transfers one element, updates the model and checks the 3-cycle busy window.
  task automatic send(input logic [15:0] d, input logic last);
    int guard = 0;
    int busy  = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk);
    model_acc = ref_add(model_acc, d);
    model_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    while (!in_ready && !out_valid && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 3) begin
      errors++;
      $display("[TB] FAIL busy_cycles: got %0d required 3 (data %h)", busy, d);
    end
  endtask

  task automatic expect_output(input logic [15:0] exp_data, input int exp_cnt, input string name);
    int guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid: out_valid=%b required 1", name, out_valid);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++;
      $display("[TB] FAIL %s_data: got %h required %h", name, out_data, exp_data);
    end
    checks++;
    if (out_count !== 8'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d required %0d", name, out_count, 8'(exp_cnt));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    model_acc = 16'h0000;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 16'h3C00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000 || out_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rdy=%b vld=%b data=%h cnt=%0d required 0 0 0000 0",
               in_ready, out_valid, out_data, out_count);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", in_ready);
    end
    model_acc = 16'h0000;
    model_cnt = 0;
  endtask

  task automatic test_basic_sum();
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    expect_output(16'h4200, 2, "one_plus_two");
  endtask

  task automatic test_stream();
    send(16'h4000, 1'b0);
    send(16'h4A00, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'hC400, 1'b1);
    expect_output(16'h4980, 4, "stream_eleven");
  endtask

  task automatic test_cancel();
    send(16'hC000, 1'b0);
    send(16'h4000, 1'b1);
    expect_output(16'h0000, 2, "cancel_zero");
  endtask

  task automatic test_overflow();
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    expect_output(ovf_value(1'b0), 2, "overflow");
    send(16'h3C00, 1'b0);
    send(16'hFC00, 1'b1);
    expect_output(16'hFC00, 2, "neg_inf_input");
    send(16'h0200, 1'b0);
    send(16'h8001, 1'b1);
    expect_output(16'h0000, 2, "subnormal_flush");
  endtask

  task automatic test_backpressure();
    logic [15:0] held_data;
    logic [7:0]  held_cnt;
    send(16'h4400, 1'b0);
    send(16'h3800, 1'b1);
    held_data = 16'h4480;
    held_cnt  = 8'd2;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_count !== held_cnt || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: vld=%b data=%h cnt=%0d rdy=%b required 1 %h %0d 0",
                 i, out_valid, out_data, out_count, in_ready, held_data, held_cnt);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    model_acc = 16'h0000;
    model_cnt = 0;
    send(16'h3C00, 1'b1);
    expect_output(16'h3C00, 1, "restart_after_hold");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_no_output: cycle %0d out_valid=%b required 0", i, out_valid);
      end
    end
    model_acc = 16'h0000;
    model_cnt = 0;
    send(16'h3C00, 1'b1);
    expect_output(16'h3C00, 1, "after_reset_mid");
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        logic [15:0] v;
        v = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
        send(v, k == len - 1);
      end
      expect_output(model_acc, model_cnt, "random_sum");
    end
  endtask

  task automatic test_count_wrap();
    for (int k = 0; k < 257; k++) send(16'h3C00, k == 256);
    expect_output(model_acc, model_cnt, "count_wrap");
  endtask

  initial begin
    model_acc = 16'h0000;
    model_cnt = 0;
    test_reset();
    test_basic_sum();
    test_stream();
    test_cancel();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
